shift_add_multiplier: RTL and testbench



---
 rtl/mult_pkg.sv | 16 +
 rtl/add_shift_controller.sv | 86 ++++++++
 rtl/shift_add_multiplier.sv | 81 ++++++++
 tb/tb_shift_add_multiplier.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAdd,
    StShift,
    StDone
  } state_e;

  // Width needed to hold a bit count running from n down to 0.
  function automatic int unsigned count_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/add_shift_controller.sv
// Sequencer for the shift-and-add multiplier: state, bit count, handshake and datapath strobes.
module add_shift_controller
  import mult_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter bit          SKIP_ZEROS = 1'b0
) (
  input  logic clock,
  input  logic n_reset,
  input  logic i_start,
  input  logic i_q_lsb,
  output logic o_busy,
  output logic o_done,
  output logic o_load,
  output logic o_add,
  output logic o_shift,
  output logic o_last,
  output logic o_finish
);

  localparam int unsigned CW = count_width(N);

  state_e          r_state, w_state_next;
  logic [CW-1:0]   r_count, w_count_next;
  logic            w_last;

  assign w_last = (r_count == CW'(1));
  assign o_last = w_last;

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    o_load       = 1'b0;
    o_add        = 1'b0;
    o_shift      = 1'b0;
    o_finish     = 1'b0;
    case (r_state)
      StIdle: begin
        o_busy = 1'b0;
        if (i_start) begin
          o_load       = 1'b1;
          w_count_next = CW'(N);
          w_state_next = StAdd;
        end
      end
      StAdd: begin
        if (i_q_lsb) begin
          o_add        = 1'b1;
          w_state_next = StShift;
        end else if (SKIP_ZEROS) begin
          // Nothing to add: fold the shift into this cycle.
          o_shift      = 1'b1;
          o_finish     = w_last;
          w_count_next = r_count - CW'(1);
          w_state_next = w_last ? StDone : StAdd;
        end else begin
          w_state_next = StShift;
        end
      end
      StShift: begin
        o_shift      = 1'b1;
        o_finish     = w_last;
        w_count_next = r_count - CW'(1);
        w_state_next = w_last ? StDone : StAdd;
      end
      StDone: begin
        o_done       = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= StIdle;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential N-bit shift-and-add multiplier, unsigned or two's-complement, with held product.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter bit          SKIP_ZEROS = 1'b0
) (
  input  logic           clock,
  input  logic           n_reset,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  logic [N:0]     r_a;
  logic [N-1:0]   r_q;
  logic [N-1:0]   r_m;
  logic           r_sgn;
  logic [2*N-1:0] r_product;

  logic           w_load, w_add, w_shift, w_last, w_finish, w_sub;
  logic [N:0]     w_m_ext, w_a_sum, w_a_shift;
  logic [N-1:0]   w_q_shift;

  add_shift_controller #(
    .N          (N),
    .SKIP_ZEROS (SKIP_ZEROS)
  ) u_ctrl (
    .clock    (clock),
    .n_reset  (n_reset),
    .i_start  (start),
    .i_q_lsb  (r_q[0]),
    .o_busy   (busy),
    .o_done   (done),
    .o_load   (w_load),
    .o_add    (w_add),
    .o_shift  (w_shift),
    .o_last   (w_last),
    .o_finish (w_finish)
  );

  // The sign bit of a two's-complement multiplier carries weight -2^(N-1), hence the subtract.
  assign w_m_ext   = r_sgn ? {r_m[N-1], r_m} : {1'b0, r_m};
  assign w_sub     = r_sgn & w_last;
  assign w_a_sum   = w_sub ? (r_a - w_m_ext) : (r_a + w_m_ext);
  assign w_a_shift = {r_sgn & r_a[N], r_a[N:1]};
  assign w_q_shift = {r_a[0], r_q[N-1:1]};

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_a       <= '0;
      r_q       <= '0;
      r_m       <= '0;
      r_sgn     <= 1'b0;
      r_product <= '0;
    end else begin
      if (w_load) begin
        r_a   <= '0;
        r_q   <= multiplier;
        r_m   <= multiplicand;
        r_sgn <= signed_mode;
      end else if (w_add) begin
        r_a <= w_a_sum;
      end else if (w_shift) begin
        r_a <= w_a_shift;
        r_q <= w_q_shift;
      end
      // Capture on the final shift so the product is visible alongside done.
      if (w_finish) begin
        r_product <= {w_a_shift[N-1:0], w_q_shift};
      end
    end
  end

  assign product = r_product;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: N=4 fixed latency, N=8 zero-skip, N=2 corner cases.
module tb_shift_add_multiplier;

  logic        clock = 1'b0;
  logic        n_reset;
  logic [2:0]  st;
  logic [2:0]  sm;
  logic [3:0]  m4, q4;
  logic [7:0]  m8, q8;
  logic [1:0]  m2, q2;

  logic        busy4, done4, busy8, done8, busy2, done2;
  logic [7:0]  prod4;
  logic [15:0] prod8;
  logic [3:0]  prod2;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  shift_add_multiplier #(.N(4), .SKIP_ZEROS(1'b0)) u_dut4 (
    .clock        (clock),
    .n_reset      (n_reset),
    .start        (st[0]),
    .signed_mode  (sm[0]),
    .multiplicand (m4),
    .multiplier   (q4),
    .busy         (busy4),
    .done         (done4),
    .product      (prod4)
  );

  shift_add_multiplier #(.N(8), .SKIP_ZEROS(1'b1)) u_dut8s (
    .clock        (clock),
    .n_reset      (n_reset),
    .start        (st[1]),
    .signed_mode  (sm[1]),
    .multiplicand (m8),
    .multiplier   (q8),
    .busy         (busy8),
    .done         (done8),
    .product      (prod8)
  );

  shift_add_multiplier #(.N(2), .SKIP_ZEROS(1'b0)) u_dut2 (
    .clock        (clock),
    .n_reset      (n_reset),
    .start        (st[2]),
    .signed_mode  (sm[2]),
    .multiplicand (m2),
    .multiplier   (q2),
    .busy         (busy2),
    .done         (done2),
    .product      (prod2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input int w, input logic s, input logic sgn,
                       input logic [7:0] m, input logic [7:0] q);
    case (w)
      0: begin st[0] = s; sm[0] = sgn; m4 = m[3:0]; q4 = q[3:0]; end
      1: begin st[1] = s; sm[1] = sgn; m8 = m;      q8 = q;      end
      default: begin st[2] = s; sm[2] = sgn; m2 = m[1:0]; q2 = q[1:0]; end
    endcase
  endtask

  function automatic logic get_busy(input int w);
    case (w)
      0: return busy4;
      1: return busy8;
      default: return busy2;
    endcase
  endfunction

  function automatic logic get_done(input int w);
    case (w)
      0: return done4;
      1: return done8;
      default: return done2;
    endcase
  endfunction

  function automatic logic [15:0] get_prod(input int w);
    case (w)
      0: return {8'h00, prod4};
      1: return prod8;
      default: return {12'h000, prod2};
    endcase
  endfunction

  function automatic logic [15:0] ref_mul8(input logic sgn, input logic [7:0] m,
                                          input logic [7:0] q);
    logic [15:0] ms, qs;
    ms = sgn ? {{8{m[7]}}, m} : {8'h00, m};
    qs = sgn ? {{8{q[7]}}, q} : {8'h00, q};
    return ms * qs;
  endfunction

  // One operation: accept, scramble inputs, then track busy/done/hold until done (bounded).
  task automatic op(input int w, input logic sgn, input logic [7:0] m, input logic [7:0] q,
                    input logic [15:0] exp, input int lat, input string tag);
    logic [15:0] prev;
    int          cyc;
    int          done_cyc;
    bit          busy_ok;
    bit          hold_ok;
    @(negedge clock);
    drive(w, 1'b1, sgn, m, q);
    @(negedge clock);
    drive(w, 1'b0, ~sgn, ~m, ~q);
    prev     = get_prod(w);
    cyc      = 1;
    done_cyc = 0;
    busy_ok  = 1'b1;
    hold_ok  = 1'b1;
    while (done_cyc == 0 && cyc <= 40) begin
      if (!get_busy(w)) busy_ok = 1'b0;
      if (get_done(w)) begin
        done_cyc = cyc;
      end else begin
        if (get_prod(w) !== prev) hold_ok = 1'b0;
        @(negedge clock);
        cyc++;
      end
    end
    check({tag, " product"}, get_prod(w), exp);
    check({tag, " done cycle"}, done_cyc, lat);
    check({tag, " busy window"}, busy_ok, 1'b1);
    check({tag, " product hold"}, hold_ok, 1'b1);
    @(negedge clock);
    check({tag, " idle after done"}, {get_busy(w), get_done(w)}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          done_n;
    int          d_cyc [3];
    logic [15:0] d_prod [3];
    bit          seen;
    logic        rs;
    logic [7:0]  rm, rq;

    n_reset = 1'b0;
    st = '0; sm = '0; m4 = '0; q4 = '0; m8 = '0; q8 = '0; m2 = '0; q2 = '0;
    repeat (2) @(negedge clock);
    check("reset busy/done n4", {busy4, done4}, 2'b00);
    check("reset product n4", prod4, 8'h00);
    check("reset product n8", prod8, 16'h0000);
    check("reset busy/done n8", {busy8, done8}, 2'b00);
    n_reset = 1'b1;

    // N=4 fixed latency 2N+1
    op(0, 1'b0, 8'd13, 8'd11, 16'h008F, 9, "u13x11");
    op(0, 1'b1, 8'h0D, 8'h05, 16'h00F1, 9, "s-3x5");
    op(0, 1'b1, 8'h08, 8'h08, 16'h0040, 9, "s-8x-8");
    op(0, 1'b0, 8'h0F, 8'h0F, 16'h00E1, 9, "u15x15");

    // N=8 zero-skip: latency N + popcount(multiplier) + 1
    op(1, 1'b0, 8'h5A, 8'h00, 16'h0000, 9,  "skip x0");
    op(1, 1'b0, 8'h02, 8'hFF, 16'h01FE, 17, "skip 2xFF");
    op(1, 1'b1, 8'h80, 8'h80, 16'h4000, 10, "skip s-128x-128");
    op(1, 1'b1, 8'hFD, 8'h07, 16'hFFEB, 12, "skip s-3x7");

    // N=2 corners
    op(2, 1'b0, 8'h03, 8'h03, 16'h0009, 5, "n2 u3x3");
    op(2, 1'b1, 8'h02, 8'h02, 16'h0004, 5, "n2 s-2x-2");
    op(2, 1'b1, 8'h02, 8'h01, 16'h000E, 5, "n2 s-2x1");

    // start held high: one accept per 2N+2 cycles, operands sampled only at accept
    @(negedge clock);
    drive(0, 1'b1, 1'b0, 8'd3, 8'd5);
    done_n = 0;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clock);
      if (c == 3) drive(0, 1'b1, 1'b0, 8'd6, 8'd7);
      if (done4) begin
        if (done_n < 3) begin
          d_cyc[done_n]  = c;
          d_prod[done_n] = {8'h00, prod4};
        end
        done_n++;
      end
    end
    drive(0, 1'b0, 1'b0, 8'd6, 8'd7);
    check("cont done count", done_n, 3);
    check("cont done 1 cycle", d_cyc[0], 9);
    check("cont done 2 cycle", d_cyc[1], 19);
    check("cont done 3 cycle", d_cyc[2], 29);
    check("cont product 1", d_prod[0], 16'h000F);
    check("cont product 2", d_prod[1], 16'h002A);
    check("cont product 3", d_prod[2], 16'h002A);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock);
      if (done4) seen = 1'b1;
    end
    check("cont drain done", seen, 1'b1);
    @(negedge clock);

    // reset during the SHIFT of bit 2 (cycle 6)
    drive(0, 1'b1, 1'b0, 8'd9, 8'd9);
    @(negedge clock);
    drive(0, 1'b0, 1'b0, 8'd9, 8'd9);
    repeat (5) @(negedge clock);
    check("abort busy before reset", busy4, 1'b1);
    n_reset = 1'b0;
    #1;
    check("abort product cleared", prod4, 8'h00);
    check("abort busy/done", {busy4, done4}, 2'b00);
    @(negedge clock);
    n_reset = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (done4 || busy4) seen = 1'b1;
    end
    check("abort no done pulse", seen, 1'b0);
    op(0, 1'b0, 8'd7, 8'd6, 16'h002A, 9, "u7x6 after abort");

    // N=8 zero-skip, both modes, against a reference multiply
    for (int i = 0; i < 30; i++) begin
      rs = 1'($urandom_range(0, 1));
      rm = 8'($urandom());
      rq = 8'($urandom());
      op(1, rs, rm, rq, ref_mul8(rs, rm, rq), 9 + $countones(rq), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
